pc_fetch_ctrl: RTL and testbench

- Sequencing controller for the program counter register and the instruction-memory fetch port.
- Each cycle it decides whether the PC advances, holds or redirects, and supplies the next-PC value and the hold (active-high) to the PC register.
- It runs a single-outstanding request/ready handshake with instruction memory and times out stuck fetches.
- It drives the IF/ID and ID/EX flush and valid controls.

---
 rtl/pc_fetch_ctrl_pkg.sv | 29 ++
 rtl/pc_fetch_ctrl_if.sv | 18 +
 rtl/pc_fetch_ctrl_nxt_mux.sv | 36 +++
 rtl/pc_fetch_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl shared types.
// State, next-PC select encoding, PC step.
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    MISS,
    DROP,
    ERR
  } state_e;

  typedef enum logic [2:0] {
    SEL_INC,
    SEL_BR,
    SEL_JMP,
    SEL_PEND,
    SEL_VEC
  } sel_e;

  localparam logic [31:0] PC_INC = 32'd4;

  function automatic logic [31:0] align4(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch handshake.
// Single outstanding request, address is the PC.
interface pc_fetch_ctrl_if;

  logic imem_req_o;
  logic imem_rdy_i;

  modport master (
    output imem_req_o,
    input  imem_rdy_i
  );

  modport slave (
    input  imem_req_o,
    output imem_rdy_i
  );

endinterface

// File: rtl/pc_fetch_ctrl_nxt_mux.sv
// Next-PC select with redirect alignment.
// Redirect targets lose bits[1:0]; flag if set.
module pc_nxt_mux
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  sel_e        sel_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] br_tgt_i,
  input  logic [31:0] jmp_tgt_i,
  input  logic [31:0] pend_i,
  output logic [31:0] nxt_o,
  output logic        misalign_o
);

  // Pick the next PC source.
  always_comb begin
    nxt_o      = pc_i + PC_INC;
    misalign_o = 1'b0;
    unique case (sel_i)
      SEL_BR: begin
        nxt_o      = align4(br_tgt_i);
        misalign_o = |br_tgt_i[1:0];
      end
      SEL_JMP: begin
        nxt_o      = align4(jmp_tgt_i);
        misalign_o = |jmp_tgt_i[1:0];
      end
      SEL_PEND: nxt_o = pend_i;
      SEL_VEC:  nxt_o = RESET_VECTOR;
      default:  nxt_o = pc_i + PC_INC;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC sequencing and fetch handshake control.
// Handles misses, pending redirects, timeouts.
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          WAIT_MAX     = 15,
  parameter int          CNT_W        = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       pc_i,
  output logic [31:0]       pc_nxt_o,
  output logic              pc_hold_o,
  pc_fetch_ctrl_if.master   imem,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic [31:0]       br_tgt_i,
  input  logic              jmp_i,
  input  logic [31:0]       jmp_tgt_i,
  output logic              if_valid_o,
  output logic              flush_ifid_o,
  output logic              flush_idex_o,
  output logic              misalign_o,
  output logic              fetch_err_o
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_q, pend_d;

  sel_e  sel;
  logic  hold, req, vld;
  logic  fl_ifid, fl_idex, mis_en;
  logic  mux_mis;
  logic  rdy, redir, tmo;
  logic [31:0] redir_tgt;

  assign rdy   = imem.imem_rdy_i;
  assign redir = br_taken_i | jmp_i;
  assign tmo   = cnt_q >= CNT_LAST;
  assign redir_tgt = br_taken_i ?
    align4(br_tgt_i) : align4(jmp_tgt_i);

  pc_nxt_mux #(
    .RESET_VECTOR (RESET_VECTOR)
  ) u_mux (
    .sel_i      (sel),
    .pc_i       (pc_i),
    .br_tgt_i   (br_tgt_i),
    .jmp_tgt_i  (jmp_tgt_i),
    .pend_i     (pend_q),
    .nxt_o      (pc_nxt_o),
    .misalign_o (mux_mis)
  );

  // State, wait counter and pending target.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Next state and per-state controls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    sel     = SEL_INC;
    hold    = 1'b1;
    req     = 1'b0;
    vld     = 1'b0;
    fl_ifid = 1'b0;
    fl_idex = 1'b0;
    mis_en  = 1'b0;
    unique case (state_q)
      BOOT: begin
        sel     = SEL_VEC;
        hold    = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        req   = 1'b1;
        cnt_d = '0;
        if (br_taken_i) begin
          sel     = SEL_BR;
          hold    = 1'b0;
          fl_ifid = 1'b1;
          fl_idex = 1'b1;
          mis_en  = 1'b1;
        end else if (jmp_i) begin
          sel     = SEL_JMP;
          hold    = 1'b0;
          fl_ifid = 1'b1;
          mis_en  = 1'b1;
        end else if (stall_i) begin
          hold = 1'b1;
        end else if (rdy) begin
          hold = 1'b0;
          vld  = 1'b1;
        end else begin
          cnt_d   = CNT_ONE;
          state_d = MISS;
        end
      end
      MISS: begin
        req = 1'b1;
        if (redir) begin
          sel     = br_taken_i ? SEL_BR : SEL_JMP;
          fl_ifid = 1'b1;
          fl_idex = br_taken_i;
          mis_en  = 1'b1;
          pend_d  = redir_tgt;
          if (rdy) begin
            hold    = 1'b0;
            cnt_d   = '0;
            state_d = RUN;
          end else if (tmo) begin
            state_d = ERR;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            state_d = DROP;
          end
        end else if (rdy) begin
          cnt_d   = '0;
          state_d = RUN;
          if (!stall_i) begin
            hold = 1'b0;
            vld  = 1'b1;
          end
        end else if (tmo) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DROP: begin
        req = 1'b1;
        sel = SEL_PEND;
        if (br_taken_i) begin
          sel     = SEL_BR;
          fl_ifid = 1'b1;
          fl_idex = 1'b1;
          mis_en  = 1'b1;
          pend_d  = align4(br_tgt_i);
        end
        if (rdy) begin
          hold    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else if (tmo) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ERR: begin
        hold = 1'b1;
      end
      default: state_d = BOOT;
    endcase
  end

  assign pc_hold_o       = hold;
  assign imem.imem_req_o = req & ~rst_i;
  assign if_valid_o      = vld & ~rst_i;
  assign flush_ifid_o    = fl_ifid & ~rst_i;
  assign flush_idex_o    = fl_idex & ~rst_i;
  assign misalign_o      = mis_en & mux_mis & ~rst_i;
  assign fetch_err_o     = state_q == ERR;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl.
// Expected outputs queued per step, checked at negedge.
module tb_pc_fetch_ctrl;

  typedef struct {
    logic        ck;
    logic [31:0] nxt;
    logic        cs;
    logic        hold;
    logic        req;
    logic        vld;
    logic        fi;
    logic        fe;
    logic        mis;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic        pc_hold;
  logic        stall, br, jmp;
  logic [31:0] br_tgt, jmp_tgt;
  logic        vld, fl_ifid, fl_idex;
  logic        mis, err;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  pc_fetch_ctrl_if imem_if();

  always #5 clk = ~clk;

  pc_fetch_ctrl #(
    .RESET_VECTOR (32'h0000_0000),
    .WAIT_MAX     (15),
    .CNT_W        (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pc_i         (pc),
    .pc_nxt_o     (pc_nxt),
    .pc_hold_o    (pc_hold),
    .imem         (imem_if),
    .stall_i      (stall),
    .br_taken_i   (br),
    .br_tgt_i     (br_tgt),
    .jmp_i        (jmp),
    .jmp_tgt_i    (jmp_tgt),
    .if_valid_o   (vld),
    .flush_ifid_o (fl_ifid),
    .flush_idex_o (fl_idex),
    .misalign_o   (mis),
    .fetch_err_o  (err)
  );

  function automatic exp_t ex(
    input logic        ck,
    input logic [31:0] nxt,
    input logic        cs,
    input logic        hold,
    input logic        req,
    input logic        v,
    input logic        fi,
    input logic        fe,
    input logic        m,
    input logic        e
  );
    exp_t r;
    r.ck = ck; r.nxt = nxt; r.cs = cs;
    r.hold = hold; r.req = req; r.vld = v;
    r.fi = fi; r.fe = fe; r.mis = m; r.err = e;
    return r;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t obs=%h exp=%h",
             tag, $time, obs, exp);
    end
  endtask

  task automatic step(
    input logic        r,
    input logic [31:0] p,
    input logic        rdy,
    input logic        st,
    input logic        b,
    input logic [31:0] bt,
    input logic        j,
    input logic [31:0] jt,
    input exp_t        e
  );
    exp_t x;
    rst = r; pc = p;
    imem_if.imem_rdy_i = rdy;
    stall = st; br = b; br_tgt = bt;
    jmp = j; jmp_tgt = jt;
    q.push_back(e);
    @(negedge clk);
    x = q.pop_front();
    chk("req", 32'(imem_if.imem_req_o), 32'(x.req));
    chk("if_valid", 32'(vld), 32'(x.vld));
    chk("flush_ifid", 32'(fl_ifid), 32'(x.fi));
    chk("flush_idex", 32'(fl_idex), 32'(x.fe));
    chk("misalign", 32'(mis), 32'(x.mis));
    if (x.ck) chk("pc_nxt", pc_nxt, x.nxt);
    if (x.cs) begin
      chk("pc_hold", 32'(pc_hold), 32'(x.hold));
      chk("fetch_err", 32'(err), 32'(x.err));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(
    input logic [31:0] p,
    input logic        rdy,
    input exp_t        e
  );
    step(1'b0, p, rdy, 1'b0, 1'b0, 32'h0,
         1'b0, 32'h0, e);
  endtask

  exp_t e_hold;
  exp_t e_err;

  initial begin
    e_hold = ex(0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    e_err  = ex(0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    // reset and boot
    step(1, 0, 1, 0, 0, 0, 0, 0,
         ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, 1, 0, 0, 0, 0, 0,
         ex(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    run(32'hDEAD_BEE0, 1,
        ex(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    run(32'h0, 1, ex(1, 32'h4, 1, 0, 1, 1, 0, 0, 0, 0));
    run(32'h4, 1, ex(1, 32'h8, 1, 0, 1, 1, 0, 0, 0, 0));
    run(32'h8, 1, ex(1, 32'hC, 1, 0, 1, 1, 0, 0, 0, 0));
    run(32'hC, 1, ex(1, 32'h10, 1, 0, 1, 1, 0, 0, 0, 0));
    // wrap
    run(32'hFFFF_FFFC, 1,
        ex(1, 32'h0, 1, 0, 1, 1, 0, 0, 0, 0));
    // branch beats jump
    step(0, 32'h40, 1, 0, 1, 32'h200, 1, 32'h102,
         ex(1, 32'h200, 1, 0, 1, 0, 1, 1, 0, 0));
    // misaligned jump
    step(0, 32'h40, 1, 0, 0, 32'h200, 1, 32'h102,
         ex(1, 32'h100, 1, 0, 1, 0, 1, 0, 1, 0));
    // stall two cycles
    step(0, 32'h100, 1, 1, 0, 0, 0, 0, e_hold);
    step(0, 32'h100, 1, 1, 0, 0, 0, 0, e_hold);
    run(32'h100, 1,
        ex(1, 32'h104, 1, 0, 1, 1, 0, 0, 0, 0));
    // miss, branch while waiting, drop
    run(32'h104, 0, e_hold);
    step(0, 32'h104, 0, 0, 1, 32'h80, 0, 0,
         ex(0, 0, 1, 1, 1, 0, 1, 1, 0, 0));
    run(32'h104, 0, e_hold);
    run(32'h104, 1,
        ex(1, 32'h80, 1, 0, 1, 0, 0, 0, 0, 0));
    run(32'h80, 1,
        ex(1, 32'h84, 1, 0, 1, 1, 0, 0, 0, 0));
    // miss returns under stall
    run(32'h84, 0, e_hold);
    step(0, 32'h84, 1, 1, 0, 0, 0, 0, e_hold);
    run(32'h84, 1,
        ex(1, 32'h88, 1, 0, 1, 1, 0, 0, 0, 0));
    // one short of timeout
    for (int i = 0; i < 14; i++) run(32'h88, 0, e_hold);
    run(32'h88, 1,
        ex(1, 32'h8C, 1, 0, 1, 1, 0, 0, 0, 0));
    // miss with jump and data same cycle
    run(32'h8C, 0, e_hold);
    step(0, 32'h8C, 1, 0, 0, 0, 1, 32'h21,
         ex(1, 32'h20, 1, 0, 1, 0, 1, 0, 1, 0));
    run(32'h20, 1,
        ex(1, 32'h24, 1, 0, 1, 1, 0, 0, 0, 0));
    // timeout
    for (int i = 0; i < 15; i++) run(32'h24, 0, e_hold);
    run(32'h24, 1, e_err);
    step(0, 32'h24, 1, 0, 1, 32'h300, 0, 0, e_err);
    // reset clears error
    step(1, 32'h24, 1, 0, 0, 0, 0, 0,
         ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 32'h24, 1, 0, 0, 0, 0, 0,
         ex(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    run(32'h24, 1,
        ex(1, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0));
    run(32'h0, 1,
        ex(1, 32'h4, 1, 0, 1, 1, 0, 0, 0, 0));
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left n=%0d exp=0",
               q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
